// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  // Controller states: idle, shifting bits, one-cycle result strobe
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width: enough to count 0..width-1, never narrower than one bit
  function automatic int calc_cw(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/half_adder.sv
// Gate-library half adder: sum and carry of two bits.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half adders.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (ci),
    .s (s),
    .c (c1)
  );

  // Only one of the two half adders can generate a carry at a time
  assign co = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder: one full adder plus a carry flip-flop,
// one operand bit per clock, start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = calc_cw(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t          state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB; a one-bit build has nothing to shift
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = fa_s;
    end else begin : g_res_wn
      assign res_next = {fa_s, res_sr[WIDTH-1:1]};
    end
  endgenerate

  // Handshake outputs decode straight from state so reset clears them at once
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Controller, operand shifters, carry flop and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= cin;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          res_sr  <= res_next;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          carry_q <= fa_co;
          if (cnt == LAST_CNT) begin
            cnt   <= '0;
            sum   <= res_next;
            cout  <= fa_co;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= cin;
            cnt     <= '0;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 builds).
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic start1;
  logic a1;
  logic b1;
  logic cin1;
  logic busy1;
  logic done1;
  logic sum1;
  logic cout1;

  int assert_count = 0;
  int fail_count   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  // Reference: plain 9-bit arithmetic
  function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {8'b0, c};
  endfunction

  // Present operands with start for one edge, then scramble them
  task automatic accept(input logic [7:0] x, input logic [7:0] y, input logic c);
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
  endtask

  // Count edges until done (bounded); flags any cycle before done where busy was low
  task automatic wait_done(input int limit, output int cycles, output bit busy_ok);
    cycles = 0;
    busy_ok = 1'b1;
    while (cycles < limit) begin
      @(posedge clk); #1;
      cycles++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 8'hA5; b = 8'h5A; cin = 1'b1;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    #12;
    assert_count++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      fail_count++;
      $display("FAIL reset_w8: got busy=%b done=%b sum=%h cout=%b expected all zero", busy, done, sum, cout);
    end
    assert_count++;
    if ({busy1, done1, sum1, cout1} !== 4'd0) begin
      fail_count++;
      $display("FAIL reset_w1: got busy=%b done=%b sum=%b cout=%b expected all zero", busy1, done1, sum1, cout1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int cycles;
    bit busy_ok;
    accept(8'h3C, 8'h5A, 1'b0);
    assert_count++;
    if (busy !== 1'b1) begin
      fail_count++;
      $display("FAIL basic_busy_after_accept: got %b expected 1", busy);
    end
    wait_done(30, cycles, busy_ok);
    assert_count++;
    if (cycles !== 8 || !busy_ok) begin
      fail_count++;
      $display("FAIL basic_latency: got %0d edges busy_ok=%b expected 8 edges busy_ok=1", cycles, busy_ok);
    end
    assert_count++;
    if ({cout, sum} !== 9'h096 || busy !== 1'b0) begin
      fail_count++;
      $display("FAIL basic_result: got cout=%b sum=%h busy=%b expected cout=0 sum=96 busy=0", cout, sum, busy);
    end
    @(posedge clk); #1;
    assert_count++;
    if (done !== 1'b0 || {cout, sum} !== 9'h096) begin
      fail_count++;
      $display("FAIL basic_done_pulse: got done=%b sum=%h expected done=0 sum held at 96", done, sum);
    end
  endtask

  task automatic test_arith();
    logic [7:0] xs[2] = '{8'hFF, 8'hFF};
    logic [7:0] ys[2] = '{8'h01, 8'hFF};
    logic       cs[2] = '{1'b0, 1'b1};
    for (int i = 0; i < 14; i++) begin
      logic [7:0] x;
      logic [7:0] y;
      logic       c;
      logic [8:0] expv;
      int cycles;
      bit busy_ok;
      if (i < 2) begin
        x = xs[i]; y = ys[i]; c = cs[i];
      end else begin
        x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
      end
      expv = ref_add(x, y, c);
      accept(x, y, c);
      wait_done(30, cycles, busy_ok);
      assert_count++;
      if (cycles !== 8 || {cout, sum} !== expv) begin
        fail_count++;
        $display("FAIL arith_%0d: %h+%h+%b got edges=%0d cout=%b sum=%h expected edges=8 cout=%b sum=%h",
                 i, x, y, c, cycles, cout, sum, expv[8], expv[7:0]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int cycles;
    bit busy_ok;
    int extra_done = 0;
    accept(8'h3C, 8'h5A, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(30, cycles, busy_ok);
    assert_count++;
    if (cycles + 3 !== 8 || {cout, sum} !== 9'h096) begin
      fail_count++;
      $display("FAIL ignore_start_result: got edges=%0d cout=%b sum=%h expected edges=8 cout=0 sum=96", cycles + 3, cout, sum);
    end
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra_done++;
    end
    assert_count++;
    if (extra_done !== 0 || sum !== 8'h96) begin
      fail_count++;
      $display("FAIL ignore_start_no_second: got %0d busy/done cycles sum=%h expected 0 and sum=96", extra_done, sum);
    end
  endtask

  task automatic test_back_to_back();
    int cycles;
    bit busy_ok;
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      wait_done(30, cycles, busy_ok);
      if (k == 3) start = 1'b0;
      assert_count++;
      if (cycles !== ((k == 0) ? 8 : 9) || !busy_ok || {cout, sum} !== 9'h002) begin
        fail_count++;
        $display("FAIL back_to_back_%0d: got edges=%0d busy_ok=%b cout=%b sum=%h expected edges=%0d busy_ok=1 cout=0 sum=02",
                 k, cycles, busy_ok, cout, sum, (k == 0) ? 8 : 9);
      end
    end
    @(posedge clk); #1;
    assert_count++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fail_count++;
      $display("FAIL back_to_back_stop: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_async_reset();
    int cycles;
    bit busy_ok;
    int stray = 0;
    accept(8'h0F, 8'h0F, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    assert_count++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      fail_count++;
      $display("FAIL async_reset: got busy=%b done=%b sum=%h cout=%b expected all zero", busy, done, sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done || busy) stray++;
    end
    assert_count++;
    if (stray !== 0 || {cout, sum} !== 9'd0) begin
      fail_count++;
      $display("FAIL async_reset_aborted: got %0d busy/done cycles sum=%h cout=%b expected 0 and zeros", stray, sum, cout);
    end
    accept(8'h3C, 8'h5A, 1'b0);
    wait_done(30, cycles, busy_ok);
    assert_count++;
    if (cycles !== 8 || !busy_ok || {cout, sum} !== 9'h096) begin
      fail_count++;
      $display("FAIL async_reset_recover: got edges=%0d cout=%b sum=%h expected edges=8 cout=0 sum=96", cycles, cout, sum);
    end
  endtask

  task automatic test_width1();
    for (int v = 0; v < 8; v++) begin
      logic [2:0] bits;
      logic [1:0] expv;
      bits = 3'(v);
      expv = 2'(bits[2]) + 2'(bits[1]) + 2'(bits[0]);
      @(negedge clk);
      a1 = bits[2]; b1 = bits[1]; cin1 = bits[0]; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0; a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
      assert_count++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        fail_count++;
        $display("FAIL width1_busy_%0d: got busy=%b done=%b expected 1 0", v, busy1, done1);
      end
      @(posedge clk); #1;
      assert_count++;
      if (done1 !== 1'b1 || {cout1, sum1} !== expv) begin
        fail_count++;
        $display("FAIL width1_result_%0d: got done=%b cout=%b sum=%b expected done=1 cout=%b sum=%b",
                 v, done1, cout1, sum1, expv[1], expv[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_width1();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
